// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and constants for the RAM1 port arbiter.
package ram_access_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    ACCESS   = 2'd2,
    COMPLETE = 2'd3
  } arb_state_t;

  // Which requester currently owns RAM1
  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_t;

  localparam int         DATA_W            = 32;
  localparam logic [2:0] MEM_STAGE_DEFAULT = 3'd3;

  // Wait-state counter width; at least one bit even with zero wait states
  function automatic int timer_width(input int wait_states);
    int w;
    w = $clog2(wait_states + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the CPU Memory stage, the host loader, RAM1 and the arbiter.
interface ram_access_arbiter_if
  import ram_access_arbiter_pkg::*;
  ;
  logic [2:0]        Stage;
  logic              Cpu_Req;
  logic              Cpu_Write;
  logic [DATA_W-1:0] Cpu_Addr;
  logic [DATA_W-1:0] Cpu_WData;
  logic [DATA_W-1:0] Cpu_RData;
  logic              Cpu_Done;
  logic              Cpu_Stall;
  logic              Host_Req;
  logic              Host_Write;
  logic [DATA_W-1:0] Host_Addr;
  logic [DATA_W-1:0] Host_WData;
  logic [DATA_W-1:0] Host_RData;
  logic              Host_Grant;
  logic              Host_Done;
  logic [DATA_W-1:0] RAM1_Address;
  logic [DATA_W-1:0] RAM1_WData;
  logic [DATA_W-1:0] RAM1_RData;
  logic              RAM1_Read;
  logic              RAM1_Write_L;

  // Arbiter side
  modport slave (
    input  Stage, Cpu_Req, Cpu_Write, Cpu_Addr, Cpu_WData,
    input  Host_Req, Host_Write, Host_Addr, Host_WData, RAM1_RData,
    output Cpu_RData, Cpu_Done, Cpu_Stall,
    output Host_RData, Host_Grant, Host_Done,
    output RAM1_Address, RAM1_WData, RAM1_Read, RAM1_Write_L
  );

  // Requester / RAM side
  modport master (
    output Stage, Cpu_Req, Cpu_Write, Cpu_Addr, Cpu_WData,
    output Host_Req, Host_Write, Host_Addr, Host_WData, RAM1_RData,
    input  Cpu_RData, Cpu_Done, Cpu_Stall,
    input  Host_RData, Host_Grant, Host_Done,
    input  RAM1_Address, RAM1_WData, RAM1_Read, RAM1_Write_L
  );

endinterface

// File: rtl/ram_wait_timer.sv
// Loadable down-counter that times the strobe phase; zero flags the last strobe cycle.
module ram_wait_timer
  import ram_access_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic Clock,
  input  logic Reset_L,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int          CW       = timer_width(WAIT_STATES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_STATES);

  logic [CW-1:0] count_reg;

  // Load on entry to the strobe phase, then count down and park at zero
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single RAM1 port between the CPU Memory stage and the host loader,
// generating RAM1 strobes with programmable wait states and stalling the CPU.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int         WAIT_STATES = 2,
  parameter logic [2:0] MEM_STAGE   = MEM_STAGE_DEFAULT
) (
  input  logic                 Clock,
  input  logic                 Reset_L,
  ram_access_arbiter_if.slave  bus
);

  arb_state_t        state_reg;
  owner_t            owner_reg;
  logic              write_reg;
  logic              ram_read_reg;
  logic              ram_write_l_reg;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic [DATA_W-1:0] host_rdata_reg;
  logic              cpu_done_reg;
  logic              host_done_reg;
  logic              host_grant_reg;
  logic              timer_zero;
  logic              cpu_request;

  // A CPU request only counts while the pipeline sits in the Memory stage
  assign cpu_request = bus.Cpu_Req & (bus.Stage == MEM_STAGE);

  // Stall until the CPU's own access reaches COMPLETE; host ownership keeps it stalled
  assign bus.Cpu_Stall = cpu_request &
                         ~((state_reg == COMPLETE) && (owner_reg == OWNER_CPU));

  ram_wait_timer #(
    .WAIT_STATES (WAIT_STATES)
  ) u_timer (
    .Clock   (Clock),
    .Reset_L (Reset_L),
    .load    (state_reg == SETUP),
    .dec     (state_reg == ACCESS),
    .zero    (timer_zero)
  );

  // Access sequencer: latches owner/address/data, drives strobes, captures read data
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg       <= IDLE;
      owner_reg       <= OWNER_CPU;
      write_reg       <= 1'b0;
      ram_read_reg    <= 1'b0;
      ram_write_l_reg <= 1'b1;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      cpu_rdata_reg   <= '0;
      host_rdata_reg  <= '0;
      cpu_done_reg    <= 1'b0;
      host_done_reg   <= 1'b0;
      host_grant_reg  <= 1'b0;
    end else begin
      cpu_done_reg  <= 1'b0;
      host_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // CPU wins a same-cycle tie
          if (cpu_request) begin
            state_reg <= SETUP;
            owner_reg <= OWNER_CPU;
            write_reg <= bus.Cpu_Write;
            addr_reg  <= bus.Cpu_Addr;
            wdata_reg <= bus.Cpu_WData;
          end else if (bus.Host_Req) begin
            state_reg      <= SETUP;
            owner_reg      <= OWNER_HOST;
            write_reg      <= bus.Host_Write;
            addr_reg       <= bus.Host_Addr;
            wdata_reg      <= bus.Host_WData;
            host_grant_reg <= 1'b1;
          end
        end
        SETUP: begin
          state_reg       <= ACCESS;
          ram_read_reg    <= ~write_reg;
          ram_write_l_reg <= ~write_reg;
        end
        ACCESS: begin
          if (timer_zero) begin
            state_reg       <= COMPLETE;
            ram_read_reg    <= 1'b0;
            ram_write_l_reg <= 1'b1;
            if (owner_reg == OWNER_CPU) begin
              cpu_done_reg <= 1'b1;
              if (!write_reg) cpu_rdata_reg <= bus.RAM1_RData;
            end else begin
              host_done_reg <= 1'b1;
              if (!write_reg) host_rdata_reg <= bus.RAM1_RData;
            end
          end
        end
        COMPLETE: begin
          state_reg      <= IDLE;
          host_grant_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.RAM1_Address = addr_reg;
  assign bus.RAM1_WData   = wdata_reg;
  assign bus.RAM1_Read    = ram_read_reg;
  assign bus.RAM1_Write_L = ram_write_l_reg;
  assign bus.Cpu_RData    = cpu_rdata_reg;
  assign bus.Cpu_Done     = cpu_done_reg;
  assign bus.Host_RData   = host_rdata_reg;
  assign bus.Host_Done    = host_done_reg;
  assign bus.Host_Grant   = host_grant_reg;

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Sequences and shares the single RAM1 port between the processor's Memory stage (loads/stores) and a host/loader port. It drives the RAM1 strobes (RAM1_Read, RAM1_Write_L) and the RAM1 address and write data, inserting a configurable number of wait states. While a CPU access is outstanding it stalls the stage counter, so the five-stage sequence holds in Memory until data is valid. It sits beside the control signal generator and replaces the previously hard-wired RAM1 strobes.

## Interface
Parameters:
- WAIT_STATES, 2, extra strobe cycles per access (0 allowed)
- MEM_STAGE, 3'd3, Stage value of the Memory stage

Ports (reset is asynchronous, active-low; one clock, Clock):
- Clock  in  1  system clock, rising edge
- Reset_L  in  1  async active-low reset
- Stage  in  3  current stage from the stage counter
- Cpu_Req  in  1  load/store request; qualified by Stage==MEM_STAGE
- Cpu_Write  in  1  1=store, 0=load
- Cpu_Addr, Cpu_WData  in  32 each  CPU address / store data
- Cpu_RData  out  32  registered load data
- Cpu_Done  out  1  one-cycle completion pulse
- Cpu_Stall  out  1  holds the stage counter while high
- Host_Req, Host_Write  in  1 each  host request / direction
- Host_Addr, Host_WData  in  32 each  host address / write data
- Host_RData  out  32  registered host read data
- Host_Grant  out  1  high while a host access owns RAM1
- Host_Done  out  1  one-cycle completion pulse
- RAM1_Address, RAM1_WData  out  32 each  to RAM1
- RAM1_RData  in  32  from RAM1
- RAM1_Read  out  1  1 = RAM output enabled, 0 = high-Z
- RAM1_Write_L  out  1  active-low write strobe

## Operation
- FSM states: IDLE, SETUP, ACCESS, COMPLETE; owner register (CPU/HOST) is latched on leaving IDLE.
- IDLE: CPU request = Cpu_Req & (Stage==MEM_STAGE).
  - If a CPU request is present, go to SETUP with owner=CPU.
  - Else if Host_Req, go to SETUP with owner=HOST.
  - CPU has fixed priority when both request in the same cycle.
- SETUP (1 cycle): address and data are latched from the owner and driven; strobes inactive.
- ACCESS (WAIT_STATES+1 cycles): read asserts RAM1_Read=1; write asserts RAM1_Write_L=0. A down-counter is loaded with WAIT_STATES on entry and the state exits when the counter reaches 0. Read data is captured into Cpu_RData or Host_RData on the last ACCESS cycle.
- COMPLETE (1 cycle): strobes inactive; owner's Done=1; then go to IDLE unconditionally.
- Address and write data are held constant from SETUP through COMPLETE.
- Cpu_Stall = CPU request & ~(state==COMPLETE & owner==CPU). It is also high while a host access blocks a pending CPU request.
- Host_Grant is high from SETUP through COMPLETE when owner==HOST. A host access is never pre-empted.
- A requester dropping Req mid-access does not abort the access; it completes and Done still pulses.
- A Req still high in IDLE after Done is treated as a new access. The host must drop Req on Host_Done.
- Reset values: state=IDLE, RAM1_Read=0, RAM1_Write_L=1, RAM1_Address=0, RAM1_WData=0, Cpu_RData=0, Host_RData=0, Done/Grant=0, Cpu_Stall=0.
- Reset asserted mid-access forces IDLE and inactive strobes immediately (async); no Done is produced.

## Timing
- Request sampled at edge T (state IDLE) -> SETUP in T+1, ACCESS T+2 .. T+2+WAIT_STATES, COMPLETE T+3+WAIT_STATES.
- Done and valid RData are visible in cycle T+3+WAIT_STATES (latency WAIT_STATES+3).
- Cpu_Stall is low in the COMPLETE cycle, so the stage advances on the following edge.
- Minimum spacing between accesses is one IDLE cycle.
- Cpu_Stall is combinational from Cpu_Req/Stage and state. All other outputs are registered.

## Structure
- Shared package: state enum (IDLE/SETUP/ACCESS/COMPLETE), owner encoding, MEM_STAGE default constant.
- One natural sub-module, ram_wait_timer: loadable down-counter, width max(1,$clog2(WAIT_STATES+1)), with a zero flag.

## Test plan
- CPU load, WAIT_STATES=2, Addr=0x10, RAM returns 0xDEADBEEF:
  - RAM1_Read high exactly 3 cycles.
  - Cpu_Done and Cpu_RData=0xDEADBEEF at T+5.
  - Cpu_Stall high T..T+4.
- CPU store, Addr=0x20, WData=0x12345678:
  - RAM1_Write_L low for 3 cycles.
  - Address and data stable from SETUP through COMPLETE.
  - RAM1_Read stays 0.
- Cpu_Req and Host_Req rise in the same cycle:
  - CPU served first.
  - Host_Grant rises only after one IDLE cycle following Cpu_Done.
- Host write in ACCESS, then CPU request arrives:
  - Host access completes uninterrupted.
  - Cpu_Stall stays high until the CPU's own COMPLETE.
- WAIT_STATES=0:
  - Strobe held for 1 cycle.
  - Done at T+3.
- Reset_L pulled low during ACCESS of a write:
  - RAM1_Write_L returns to 1 asynchronously, with no Done.
  - After release, state is IDLE and all outputs are at reset values.
